// File: rtl/mcif_rd_client_port.sv
// MCIF read responder for one DMA client: credit-throttled AR issue, R pass-through, burst tracking.
// Optional MCIF_RD_ERR_CHK_EN adds rresp/rlast checking to the sticky rd_err flag.
module mcif_rd_client_port #(
    parameter int LEN_W    = 4,
    parameter int DAT_W    = 128,
    parameter int FIFO_DEP = 64,
    parameter int CRD_W    = 7,
    parameter int MAX_OTS  = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      rd_req_vld,
    output logic                      rd_req_rdy,
    input  logic [LEN_W+63:0]         rd_req_pd,
    output logic                      axi_arvalid,
    input  logic                      axi_arready,
    output logic [31:0]               axi_araddr,
    output logic [7:0]                axi_arlen,
    input  logic                      axi_rvalid,
    output logic                      axi_rready,
    input  logic [DAT_W-1:0]          axi_rdata,
    input  logic                      axi_rlast,
    input  logic [1:0]                axi_rresp,
    output logic                      resp_vld,
    input  logic                      resp_rdy,
    output logic [DAT_W-1:0]          resp_pd,
    input  logic                      rd_fifo_pop,
    output logic                      rd_err,
    output logic [1:0]                dbgState,
    output logic [CRD_W-1:0]          dbgCredit,
    output logic [$clog2(MAX_OTS):0]  dbgOts
);
    // Valid/ready: a transfer happens on every rising edge where both valid and ready are high;
    // valid and its payload stay stable until that edge.
    localparam int OTS_W = $clog2(MAX_OTS) + 1;
    localparam int PTR_W = $clog2(MAX_OTS);
    localparam int SUM_W = CRD_W + 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_ISSUE = 2'd2;

    logic [1:0]        state;
    logic              started;
    logic [31:0]       reqAddr;
    logic [LEN_W-1:0]  reqLen;
    logic [CRD_W-1:0]  credit;
    logic [OTS_W-1:0]  ots;
    logic [OTS_W-1:0]  otsNxt;
    logic [LEN_W-1:0]  beatCnt;
    logic [PTR_W-1:0]  wrPtr;
    logic [PTR_W-1:0]  rdPtr;
    logic [LEN_W-1:0]  lenMem [MAX_OTS];
    logic              rdErr;

    logic              reqHs;
    logic              arHs;
    logic              rHs;
    logic              gate;
    logic [SUM_W-1:0]  reqBeats;
    logic [SUM_W-1:0]  creditSum;
    logic              popOverflow;
    logic              rValidBeat;
    logic              orphan;
    logic              lastBeat;
    logic              burstDone;
    logic              protoErr;
    logic              unusedBits;

    assign reqHs      = rd_req_vld & rd_req_rdy;
    assign arHs       = axi_arvalid & axi_arready;
    assign rHs        = axi_rvalid & resp_rdy;
    assign reqBeats   = SUM_W'(reqLen) + SUM_W'(1);
    assign gate       = (state == ST_WAIT) && ({1'b0, credit} >= reqBeats) && (ots < OTS_W'(MAX_OTS));

    // Deduction and returned pop may land together; a pop that would push past full is dropped.
    assign creditSum   = {1'b0, credit} - (gate ? reqBeats : SUM_W'(0)) + SUM_W'(rd_fifo_pop);
    assign popOverflow = rd_fifo_pop && (creditSum > SUM_W'(FIFO_DEP));

    assign rValidBeat = rHs && (ots != '0);
    assign orphan     = rHs && (ots == '0);
    assign lastBeat   = (beatCnt == lenMem[rdPtr]);
    assign burstDone  = rValidBeat && lastBeat;

`ifdef MCIF_RD_ERR_CHK_EN
    assign protoErr   = rValidBeat && ((axi_rresp != 2'b00) || (axi_rlast != lastBeat));
    assign unusedBits = ^rd_req_pd[63:32];
`else
    assign protoErr   = 1'b0;
    assign unusedBits = ^{rd_req_pd[63:32], axi_rlast, axi_rresp};
`endif

    always_comb begin
        otsNxt = ots;
        case ({arHs, burstDone})
            2'b10:   otsNxt = ots + OTS_W'(1);
            2'b01:   otsNxt = ots - OTS_W'(1);
            default: otsNxt = ots;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            started <= 1'b0;
            reqAddr <= '0;
            reqLen  <= '0;
            credit  <= CRD_W'(FIFO_DEP);
            ots     <= '0;
            beatCnt <= '0;
            wrPtr   <= '0;
            rdPtr   <= '0;
            rdErr   <= 1'b0;
        end else begin
            started <= 1'b1;
            case (state)
                ST_IDLE: if (reqHs) begin
                    reqAddr <= rd_req_pd[31:0];
                    reqLen  <= rd_req_pd[LEN_W+63:64];
                    state   <= ST_WAIT;
                end
                ST_WAIT:  if (gate) state <= ST_ISSUE;
                ST_ISSUE: if (axi_arready) state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
            credit <= popOverflow ? CRD_W'(creditSum - SUM_W'(1)) : CRD_W'(creditSum);
            ots    <= otsNxt;
            if (arHs) wrPtr <= wrPtr + PTR_W'(1);
            if (burstDone) rdPtr <= rdPtr + PTR_W'(1);
            if (rValidBeat) beatCnt <= lastBeat ? '0 : beatCnt + LEN_W'(1);
            if (popOverflow || orphan || protoErr) rdErr <= 1'b1;
        end
    end

    // Length FIFO storage needs no reset: entries are only read while ots is non-zero.
    always_ff @(posedge clk) begin
        if (arHs) lenMem[wrPtr] <= reqLen;
    end

    assign rd_req_rdy  = started && (state == ST_IDLE);
    assign axi_arvalid = (state == ST_ISSUE);
    assign axi_araddr  = reqAddr;
    assign axi_arlen   = 8'(reqLen);
    assign axi_rready  = resp_rdy;
    assign resp_vld    = axi_rvalid;
    assign resp_pd     = axi_rdata;
    assign rd_err      = rdErr;
    assign dbgState    = state;
    assign dbgCredit   = credit;
    assign dbgOts      = ots;

endmodule
